// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store memory controller:
//               access size encodings, controller state encoding and the
//               alignment check applied to every incoming request.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size encodings as presented by the core
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;   // reserved, always rejected

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RMW_RD   = 3'd2,
        RMW_WR   = 3'd3,
        WR       = 3'd4,
        RESP     = 3'd5,
        ERR_RESP = 3'd6
    } lsu_state_t;

    // A request is rejected when its size is reserved or its byte address is
    // not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane steering. Extracts and sign/zero
//               extends the addressed byte/half/word of a memory word for
//               loads, and merges right-justified store data into the
//               addressed lanes of a memory word for sub-word stores.
//               Lanes are little-endian: byte k lives in bits [8k+7:8k].
// Ports       : addr_lo     byte offset within the word
//               size        access size (SZ_B/SZ_H/SZ_W)
//               is_unsigned 1 = zero-extend loads, 0 = sign-extend
//               rdata       word read from memory
//               wdata       store data, right-justified
//               load_data   aligned, extended load result
//               merge_data  rdata with the addressed lanes replaced
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte     = rdata[{addr_lo, 3'b000} +: 8];
        w_half     = rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data  = rdata;
        merge_data = wdata;
        case (size)
            SZ_B: begin
                load_data  = {{24{~is_unsigned & w_byte[7]}}, w_byte};
                merge_data = rdata;
                merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data  = {{16{~is_unsigned & w_half[15]}}, w_half};
                merge_data = rdata;
                merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = rdata;
                merge_data = wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Initiator for a stalling word-memory port. Takes one RISC-V
//               load/store at a time from the core, holds the memory request
//               until mem_ready, performs read-modify-write for byte/half
//               stores and returns aligned, extended load data with a
//               one-cycle response pulse. Misaligned/illegal requests,
//               memory errors and ready timeouts complete with resp_err.
// Ports       : req_*   core request (accepted only while req_ready)
//               resp_*  one-cycle completion pulse with data and error
//               mem_*   word memory handshake (enable/wr/ready/err)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              mem_err
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(TIMEOUT);

    lsu_state_t          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [1:0]          r_size;
    logic [1:0]          r_addr_lo;
    logic                r_unsigned;
    logic [DATA_W-1:0]   r_wdata;

    logic [DATA_W-1:0]   w_load;
    logic [DATA_W-1:0]   w_merge;
    logic                w_misaligned;
    logic                w_timeout;

    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    // Last allowed non-ready cycle of the current access
    assign w_timeout    = (r_cnt == c_cnt_last);

    lsu_lane_align u_lane_align (
        .addr_lo     (r_addr_lo),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .rdata       (mem_rdata),
        .wdata       (r_wdata),
        .load_data   (w_load),
        .merge_data  (w_merge)
    );

    // All outputs are registered and updated together with the state, so
    // every mem_* value is constant for the whole time a state is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_size     <= '0;
            r_addr_lo  <= '0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // Response fields are pulses: cleared unless a transition sets them
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr_lo  <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        r_cnt      <= '0;
                        req_ready  <= 1'b0;
                        if (w_misaligned) begin
                            r_state    <= ERR_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            mem_enable <= 1'b1;
                            mem_addr   <= req_addr[ADDR_W+1:2];
                            if (!req_we) begin
                                r_state <= RD;
                                mem_wr  <= 1'b0;
                            end else if (req_size == SZ_W) begin
                                r_state   <= WR;
                                mem_wr    <= 1'b1;
                                mem_wdata <= req_wdata;
                            end else begin
                                r_state <= RMW_RD;
                                mem_wr  <= 1'b0;
                            end
                        end
                    end
                end
                RD, RMW_RD: begin
                    if (mem_ready) begin
                        if (mem_err) begin
                            r_state    <= ERR_RESP;
                            mem_enable <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (r_state == RD) begin
                            r_state    <= RESP;
                            mem_enable <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_rdata <= w_load;
                        end else begin
                            // Keep enable high straight into the write phase
                            r_state   <= RMW_WR;
                            mem_wr    <= 1'b1;
                            mem_wdata <= w_merge;
                            r_cnt     <= '0;
                        end
                    end else if (w_timeout) begin
                        r_cnt      <= c_cnt_max;
                        r_state    <= ERR_RESP;
                        mem_enable <= 1'b0;
                        mem_wr     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                WR, RMW_WR: begin
                    if (mem_ready) begin
                        r_state    <= mem_err ? ERR_RESP : RESP;
                        mem_enable <= 1'b0;
                        mem_wr     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= mem_err;
                    end else if (w_timeout) begin
                        r_cnt      <= c_cnt_max;
                        r_state    <= ERR_RESP;
                        mem_enable <= 1'b0;
                        mem_wr     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                RESP, ERR_RESP: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    req_ready  <= 1'b1;
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Self-checking bench for lsu_mem_ctrl. A small stalling word
//               memory model answers the controller; expected responses are
//               queued at issue time and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    localparam int ADDR_W = 14;
    localparam int TMO    = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              mem_err;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_err      (mem_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   en_cycles = 0;
    int   hold_viol = 0;
    bit   hold_chk  = 1'b1;

    // ---------------- stalling memory model ----------------
    logic [31:0] mem [0:15];
    int          en_run     = 0;
    int          stall_n    = 0;
    bit          never_rdy  = 1'b0;
    bit          err_inj    = 1'b0;
    int          rd_cnt     = 0;
    int          wr_cnt     = 0;
    logic [31:0] last_wdata = 32'h0;

    // Ready rises once enable has been held stall_n cycles
    assign mem_ready = mem_enable && !never_rdy && (en_run >= stall_n);
    assign mem_err   = err_inj;
    assign mem_rdata = mem[mem_addr[3:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n || !mem_enable || mem_ready) en_run <= 0;
        else                                    en_run <= en_run + 1;
        if (rst_n && mem_enable && mem_ready) begin
            if (mem_wr) begin
                wr_cnt     <= wr_cnt + 1;
                last_wdata <= mem_wdata;
                if (!err_inj) mem[mem_addr[3:0]] <= mem_wdata;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- response monitor ----------------
    initial begin : monitor
        exp_t              e;
        logic              p_en   = 1'b0;
        logic              p_rdy  = 1'b0;
        logic              p_wr   = 1'b0;
        logic [ADDR_W-1:0] p_addr = '0;
        logic [31:0]       p_wd   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp actual=resp_valid required=no_response err=%0b", resp_err);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("resp_enable_low", 32'(mem_enable), 32'h0);
                end
            end
            if (rst_n && mem_enable) en_cycles++;
            if (rst_n && hold_chk && p_en && !p_rdy) begin
                if (mem_enable !== 1'b1 || mem_wr !== p_wr ||
                    mem_addr !== p_addr || mem_wdata !== p_wd)
                    hold_viol++;
            end
            p_en   = rst_n && mem_enable;
            p_rdy  = mem_ready;
            p_wr   = mem_wr;
            p_addr = mem_addr;
            p_wd   = mem_wdata;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_wait actual=0 required=1");
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        if (push) sb.push_back('{rdata: exp_rd, err: exp_err, cyc: cyc + lat});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout actual=%0d_pending required=0_pending", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin : stim
        int r0, w0, e0, h0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        // Reset values
        #12;
        chk("rst_req_ready",  32'(req_ready),  32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata,      32'h0);
        chk("rst_resp_err",   32'(resp_err),   32'h0);
        chk("rst_mem_enable", 32'(mem_enable), 32'h0);
        chk("rst_mem_wr",     32'(mem_wr),     32'h0);
        chk("rst_mem_addr",   32'(mem_addr),   32'h0);
        chk("rst_mem_wdata",  mem_wdata,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then lane extraction loads
        issue(1, 2'b10, 0, 16'h0010, 32'h8899AABB, 32'h0,        0, 2, 1);
        issue(0, 2'b00, 0, 16'h0012, 32'h0,        32'hFFFFFF99, 0, 2, 1);
        issue(0, 2'b00, 1, 16'h0012, 32'h0,        32'h00000099, 0, 2, 1);
        issue(0, 2'b00, 1, 16'h0013, 32'h0,        32'h00000088, 0, 2, 1);
        issue(0, 2'b00, 0, 16'h0010, 32'h0,        32'hFFFFFFBB, 0, 2, 1);
        issue(0, 2'b01, 0, 16'h0012, 32'h0,        32'hFFFF8899, 0, 2, 1);
        issue(0, 2'b01, 1, 16'h0010, 32'h0,        32'h0000AABB, 0, 2, 1);
        issue(0, 2'b10, 0, 16'h0010, 32'h0,        32'h8899AABB, 0, 2, 1);
        drain();

        // Read-modify-write half store
        issue(1, 2'b10, 0, 16'h0010, 32'h11223344, 32'h0, 0, 2, 1);
        drain();
        r0 = rd_cnt;
        w0 = wr_cnt;
        issue(1, 2'b01, 0, 16'h0012, 32'h0000BEEF, 32'h0, 0, 3, 1);
        drain();
        chk("rmw_reads",  32'(rd_cnt - r0), 32'h1);
        chk("rmw_writes", 32'(wr_cnt - w0), 32'h1);
        chk("rmw_wdata",  last_wdata,       32'hBEEF3344);
        issue(0, 2'b10, 0, 16'h0010, 32'h0,        32'hBEEF3344, 0, 2, 1);
        issue(1, 2'b00, 0, 16'h0011, 32'hFFFFFF5A, 32'h0,        0, 3, 1);
        issue(0, 2'b10, 0, 16'h0010, 32'h0,        32'hBEEF5A44, 0, 2, 1);
        drain();

        // Misaligned / illegal: immediate error, no memory activity
        e0 = en_cycles;
        issue(0, 2'b10, 0, 16'h0006, 32'h0, 32'h0, 1, 1, 1);
        issue(0, 2'b01, 0, 16'h0005, 32'h0, 32'h0, 1, 1, 1);
        issue(1, 2'b11, 0, 16'h0010, 32'h0, 32'h0, 1, 1, 1);
        drain();
        chk("misaligned_no_enable", 32'(en_cycles - e0), 32'h0);

        // Stalled load and stalled sub-word store: request must hold
        h0      = hold_viol;
        stall_n = 5;
        issue(0, 2'b10, 0, 16'h0010, 32'h0, 32'hBEEF5A44, 0, 7, 1);
        drain();
        stall_n = 2;
        issue(1, 2'b00, 0, 16'h0013, 32'h00000066, 32'h0, 0, 7, 1);
        drain();
        stall_n = 0;
        chk("stall_hold_stable", 32'(hold_viol - h0), 32'h0);
        issue(0, 2'b10, 0, 16'h0010, 32'h0, 32'h66EF5A44, 0, 2, 1);
        drain();

        // Ready never arrives: abort after TMO wait cycles
        never_rdy = 1'b1;
        hold_chk  = 1'b0;
        e0        = en_cycles;
        issue(0, 2'b10, 0, 16'h0010, 32'h0, 32'h0, 1, TMO + 1, 1);
        drain();
        chk("timeout_enable_cycles", 32'(en_cycles - e0), 32'(TMO));
        chk("timeout_enable_low",    32'(mem_enable),     32'h0);
        never_rdy = 1'b0;
        hold_chk  = 1'b1;

        // Memory error on write, read and RMW read
        err_inj = 1'b1;
        w0      = wr_cnt;
        issue(1, 2'b10, 0, 16'h0010, 32'hDEADBEEF, 32'h0, 1, 2, 1);
        issue(0, 2'b10, 0, 16'h0010, 32'h0,        32'h0, 1, 2, 1);
        issue(1, 2'b00, 0, 16'h0010, 32'h00000011, 32'h0, 1, 2, 1);
        drain();
        chk("mem_err_writes", 32'(wr_cnt - w0), 32'h1);
        err_inj = 1'b0;
        issue(0, 2'b10, 0, 16'h0010, 32'h0, 32'h66EF5A44, 0, 2, 1);
        drain();

        // Reset while the RMW read is stalled
        stall_n = 6;
        w0      = wr_cnt;
        issue(1, 2'b00, 0, 16'h0010, 32'h00000077, 32'h0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_rmw_rd", {30'h0, mem_enable, mem_wr}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_enable", 32'(mem_enable), 32'h0);
        chk("midrst_mem_wr",     32'(mem_wr),     32'h0);
        chk("midrst_mem_addr",   32'(mem_addr),   32'h0);
        chk("midrst_mem_wdata",  mem_wdata,       32'h0);
        chk("midrst_req_ready",  32'(req_ready),  32'h1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        stall_n = 0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready),  32'h1);
        chk("post_rst_no_write",  32'(wr_cnt - w0), 32'h0);
        issue(0, 2'b10, 0, 16'h0010, 32'h0, 32'h66EF5A44, 0, 2, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
